adder_pipelined: RTL

ADDER_PIPELINED -- requirements
Module: adder_pipelined

---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_pipelined_if.sv | 36 +++
 rtl/adder_chunk.sv | 31 +++
 rtl/adder_pipelined.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared constants and helpers for the pipelined adder.
//            Holds the mode encoding and the per-stage chunk width calculation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

   // Mode encoding carried on the 'sub' input
   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // Width of the slice each stage adds. Returns 0 for an illegal
   // configuration so the caller can raise an elaboration error.
   function automatic int chunk_width(input int bit_width, input int num_stages);
      if ((bit_width < 2) || (num_stages < 1) || ((bit_width % num_stages) != 0)) begin
         return 0;
      end
      return bit_width / num_stages;
   endfunction

endpackage : adder_pkg

`default_nettype wire

// File: rtl/adder_pipelined_if.sv
// ============================================================================
// Module   : adder_pipelined_if
// Purpose  : Valid/ready operand and result bundle of the pipelined adder.
//            'master' drives operands and consumes results; 'slave' is the
//            adder itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_pipelined_if #(
   parameter int BIT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BIT_WIDTH-1:0] a;
   logic [BIT_WIDTH-1:0] b;
   logic                 carry_in;
   logic                 sub;
   logic                 out_valid;
   logic                 out_ready;
   logic [BIT_WIDTH-1:0] sum;
   logic                 carry_out;
   logic                 overflow;

   modport master (
      output in_valid, a, b, carry_in, sub, out_ready,
      input  in_ready, out_valid, sum, carry_out, overflow
   );

   modport slave (
      input  in_valid, a, b, carry_in, sub, out_ready,
      output in_ready, out_valid, sum, carry_out, overflow
   );
endinterface : adder_pipelined_if

`default_nettype wire

// File: rtl/adder_chunk.sv
// ============================================================================
// Module   : adder_chunk
// Purpose  : Combinational WIDTH-bit adder slice with carry in/out. Also
//            reports the carry into its MSB so the final slice can derive
//            signed overflow as (carry into MSB) xor (carry out of MSB).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_chunk #(
   parameter int WIDTH = 4
) (
   input  wire logic [WIDTH-1:0] a,
   input  wire logic [WIDTH-1:0] b,
   input  wire logic             carry_in,
   output logic      [WIDTH-1:0] sum,
   output logic                  carry_out,
   output logic                  msb_carry_in
);

   logic [WIDTH:0] w_full;

   assign w_full       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
   assign sum          = w_full[WIDTH-1:0];
   assign carry_out    = w_full[WIDTH];
   // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly
   assign msb_carry_in = a[WIDTH-1] ^ b[WIDTH-1] ^ w_full[WIDTH-1];

endmodule : adder_chunk

`default_nettype wire

// File: rtl/adder_pipelined.sv
// ============================================================================
// Module   : adder_pipelined
// Purpose  : Carry-pipelined add/subtract unit. Stage k adds operand slice k
//            plus the carry registered by stage k-1; unconsumed operand bits
//            ride along in skew registers and finished sum slices are carried
//            forward so the full result lines up at the last stage. A single
//            global advance (output empty or accepted) stalls every stage.
//            Optional build macro: ADDER_SATURATE_EN clamps the sum to the
//            most positive / most negative value on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_pipelined
   import adder_pkg::*;
#(
   parameter int BIT_WIDTH  = 8,
   parameter int NUM_STAGES = 2
) (
   input wire logic          clk,
   input wire logic          rst,
   adder_pipelined_if.slave  bus
);

   localparam int CHUNK = chunk_width(BIT_WIDTH, NUM_STAGES);
   // Keeps port widths legal while the error below reports a bad setup
   localparam int CW    = (CHUNK > 0) ? CHUNK : 1;

   if (CHUNK == 0) begin : g_param_check
      $error("adder_pipelined: BIT_WIDTH must be >= 2 and divisible by NUM_STAGES >= 1");
   end

   logic                 w_advance;
   logic                 w_accept;
   logic [BIT_WIDTH-1:0] w_b_eff;
   logic                 w_cin_eff;

   // The whole pipe moves only when the result slot is empty or being taken
   assign w_advance    = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = w_advance;
   assign w_accept     = bus.in_valid && w_advance;

   // Subtract is a + ~b + 1; carry_in only matters in add mode
   assign w_b_eff   = (bus.sub == SUB) ? ~bus.b : bus.b;
   assign w_cin_eff = (bus.sub == SUB) ? 1'b1 : bus.carry_in;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic                 w_vin;
      logic                 w_cin;
      logic [BIT_WIDTH-1:0] w_a_in;
      logic [BIT_WIDTH-1:0] w_b_in;
      logic [BIT_WIDTH-1:0] w_sum_prev;
      logic [BIT_WIDTH-1:0] w_sum_next;
      logic [CW-1:0]        w_chunk_sum;
      logic                 w_cout;
      logic                 w_msb_cin;

      logic                 r_valid;
      logic                 r_carry;
      logic [BIT_WIDTH-1:0] r_sum;
      logic [BIT_WIDTH-1:0] r_a;
      logic [BIT_WIDTH-1:0] r_b;

      if (k == 0) begin : g_first
         assign w_vin      = w_accept;
         assign w_cin      = w_cin_eff;
         assign w_a_in     = bus.a;
         assign w_b_in     = w_b_eff;
         assign w_sum_prev = '0;
      end else begin : g_next
         assign w_vin      = g_stage[k-1].r_valid;
         assign w_cin      = g_stage[k-1].r_carry;
         assign w_a_in     = g_stage[k-1].r_a;
         assign w_b_in     = g_stage[k-1].r_b;
         assign w_sum_prev = g_stage[k-1].r_sum;
      end

      adder_chunk #(
         .WIDTH (CW)
      ) u_chunk (
         .a            (w_a_in[k*CW +: CW]),
         .b            (w_b_in[k*CW +: CW]),
         .carry_in     (w_cin),
         .sum          (w_chunk_sum),
         .carry_out    (w_cout),
         .msb_carry_in (w_msb_cin)
      );

      // Merge this stage's slice into the partial sum carried forward
      always_comb begin
         w_sum_next               = w_sum_prev;
         w_sum_next[k*CW +: CW]   = w_chunk_sum;
      end

      // Stage register: valid slot, carry, partial sum and operand skew
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_a     <= '0;
            r_b     <= '0;
         end else if (w_advance) begin
            r_valid <= w_vin;
            r_carry <= w_cout;
            r_sum   <= w_sum_next;
            r_a     <= w_a_in;
            r_b     <= w_b_in;
         end
      end

      if (k == NUM_STAGES - 1) begin : g_last
         logic r_ovf;

         // Signed overflow of the complete word, captured with the last slice
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_ovf <= 1'b0;
            end else if (w_advance) begin
               r_ovf <= w_msb_cin ^ w_cout;
            end
         end

         assign bus.out_valid = r_valid;
         assign bus.carry_out = r_carry;
         assign bus.overflow  = r_ovf;

`ifdef ADDER_SATURATE_EN
         logic r_pos;

         // On overflow both operand signs agree, so A's sign picks the direction
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_pos <= 1'b0;
            end else if (w_advance) begin
               r_pos <= ~w_a_in[BIT_WIDTH-1];
            end
         end

         assign bus.sum = !r_ovf ? r_sum :
                          r_pos  ? {1'b0, {(BIT_WIDTH-1){1'b1}}} :
                                   {1'b1, {(BIT_WIDTH-1){1'b0}}};
`else
         assign bus.sum = r_sum;
`endif
      end
   end

endmodule : adder_pipelined

`default_nettype wire
